// File: rtl/avst_rr_arbiter_if.sv
// Avalon-ST bundle between NUM_REQ sources, the round-robin arbiter and one FIFO sink.
// The master side is the arbiter; the slave side is the surrounding sources and sink.
interface avst_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int CH_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            in_valid;
    logic [NUM_REQ-1:0]            in_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [CH_W-1:0]               out_channel;
    logic                          busy;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_channel, busy
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_channel, busy
    );
endinterface

// File: rtl/avst_rr_arbiter.sv
// Round-robin arbiter: grants one Avalon-ST source for up to MAX_BURST beats and forwards
// each accepted beat through a single-entry output register tagged with its channel.
module avst_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input logic               clk,
    input logic               areset,
    avst_rr_arbiter_if.master bus
);
    localparam int CH_W = $clog2(NUM_REQ);
    localparam logic [CH_W-1:0] LAST_IDX   = CH_W'(NUM_REQ - 1);
    localparam logic [CH_W:0]   NREQ_W     = (CH_W + 1)'(NUM_REQ);
    localparam logic [7:0]      BURST_LAST = 8'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state, state_nxt;
    logic [CH_W-1:0]       g, g_nxt;
    logic [CH_W-1:0]       rr_ptr, rr_nxt;
    logic [7:0]            beat_cnt, beat_nxt;
    logic [CH_W-1:0]       pick_idx, idx;
    logic [CH_W:0]         sum;
    logic                  pick_found;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  slot_free;
    logic                  xfer;
    logic [NUM_REQ-1:0]    ready;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]       out_channel_q;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins; the
    // explicit wrap keeps non-power-of-two NUM_REQ from ever producing an index >= NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        idx        = '0;
        sum        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (CH_W + 1)'(k);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[CH_W-1:0];
            if (bus.in_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g == CH_W'(i)) begin
                sel_valid = bus.in_valid[i];
                sel_data  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign slot_free = !out_valid_q || bus.out_ready;
    assign xfer      = (state == GRANT) && sel_valid && slot_free;

    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready[i] = (state == GRANT) && slot_free && (g == CH_W'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                    g_nxt     = pick_idx;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    beat_nxt = beat_cnt + 8'd1;
                end
                // A stalled sink is not a release: beat_cnt and the grant simply hold.
                if ((xfer && (beat_cnt == BURST_LAST)) || !sel_valid) begin
                    state_nxt = IDLE;
                    rr_nxt    = (g == LAST_IDX) ? '0 : g + CH_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            g             <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
        end else begin
            state    <= state_nxt;
            g        <= g_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= beat_nxt;
            if (xfer) begin
                out_valid_q   <= 1'b1;
                out_data_q    <= sel_data;
                out_channel_q <= g;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_channel = out_channel_q;
    assign bus.busy        = (state == GRANT);
endmodule

// File: tb/tb_avst_rr_arbiter.sv
// Self-checking bench for avst_rr_arbiter: counted sources feed a scoreboard of accepted
// beats, while arbitration order, burst gaps, stalls and reset are checked against constants.
module tb_avst_rr_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [3:0] mask;
        int         exp_ch;
        int         exp_lat;
    } vec_t;

    logic clk;
    logic areset;
    logic or_val;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   src_left [NR];
    int   src_cnt  [NR];
    beat_t sb[$];
    beat_t out_log[$];
    int    acc_ch[$];
    int    acc_cyc[$];
    vec_t  vecs[6];

    avst_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    avst_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        logic [NR-1:0]    v;
        logic [NR*DW-1:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < NR; i++) begin
            v[i] = (src_left[i] > 0);
            d[i*DW +: DW] = 32'(32'h100 * (i + 1) + src_cnt[i]);
        end
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = or_val;
    endtask

    function automatic bit pending();
        bit p = (sb.size() != 0) || bus.out_valid || bus.busy;
        for (int i = 0; i < NR; i++) begin
            if (src_left[i] > 0) p = 1'b1;
        end
        return p;
    endfunction

    // Sample on the falling edge what the next rising edge will commit, then re-drive.
    task automatic tick();
        beat_t b, e;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            b.ch   = bus.out_channel;
            b.data = bus.out_data;
            out_log.push_back(b);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got beat %0h ch %0d, none expected", b.data, b.ch);
            end else begin
                e = sb.pop_front();
                chk("sb_data", 64'(b.data), 64'(e.data));
                chk("sb_channel", 64'(b.ch), 64'(e.ch));
            end
        end
        chk("in_ready_onehot0", 64'($onehot0(bus.in_ready)), 64'd1);
        for (int i = 0; i < NR; i++) begin
            if (bus.in_valid[i] && bus.in_ready[i]) begin
                b.ch   = 2'(i);
                b.data = bus.in_data[i*DW +: DW];
                sb.push_back(b);
                acc_ch.push_back(i);
                acc_cyc.push_back(cyc);
                src_left[i]--;
                src_cnt[i]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run_idle(input string name, input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            tick();
            n++;
        end
        if (pending()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic wait_acc(input string name, input int count, input int budget);
        int n = 0;
        while (acc_ch.size() < count && n < budget) begin
            tick();
            n++;
        end
        if (acc_ch.size() < count) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d beats accepted, required %0d", name, acc_ch.size(), count);
        end
    endtask

    task automatic clear_logs();
        sb.delete();
        out_log.delete();
        acc_ch.delete();
        acc_cyc.delete();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        or_val = 1'b1;
        for (int i = 0; i < NR; i++) begin
            src_left[i] = 0;
            src_cnt[i]  = 0;
        end
        drive();
        @(posedge clk);
        #1;
        areset = 1'b0;
        clear_logs();
    endtask

    initial begin
        int n;
        int exp_gap;
        int exp_t3 [5];
        int exp_t5 [6];

        vecs[0] = '{mask: 4'b0001, exp_ch: 0, exp_lat: 2};
        vecs[1] = '{mask: 4'b0110, exp_ch: 1, exp_lat: 2};
        vecs[2] = '{mask: 4'b1000, exp_ch: 3, exp_lat: 2};
        vecs[3] = '{mask: 4'b1010, exp_ch: 1, exp_lat: 2};
        vecs[4] = '{mask: 4'b1100, exp_ch: 2, exp_lat: 2};
        vecs[5] = '{mask: 4'b1111, exp_ch: 0, exp_lat: 2};
        exp_t3 = '{6, 1, 1, 2, 1};
        exp_t5 = '{1, 1, 3, 3, 3, 3};

        areset = 1'b0;
        or_val = 1'b1;
        for (int i = 0; i < NR; i++) begin
            src_left[i] = 0;
            src_cnt[i]  = 0;
        end
        drive();
        #1 areset = 1'b1;
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_channel", 64'(bus.out_channel), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        do_reset();

        // First grant from rr_ptr=0 and request-to-accept latency
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < NR; i++) begin
                if (vecs[v].mask[i]) src_left[i] = 1;
            end
            drive();
            n = 0;
            while (acc_ch.size() == 0 && n < 10) begin
                tick();
                n++;
            end
            if (acc_ch.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vec%0d_grant: no beat accepted, required channel %0d", v, vecs[v].exp_ch);
            end else begin
                chk($sformatf("vec%0d_first_ch", v), 64'(acc_ch[0]), 64'(vecs[v].exp_ch));
                chk($sformatf("vec%0d_latency", v), 64'(n), 64'(vecs[v].exp_lat));
            end
            run_idle($sformatf("vec%0d", v), 60);
        end

        // Single source, 10 beats, bursts of 4 with one idle cycle between grants
        do_reset();
        src_left[0] = 10;
        drive();
        run_idle("t1", 200);
        chk("t1_beats", 64'(out_log.size()), 64'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < out_log.size()) begin
                chk($sformatf("t1_data%0d", k), 64'(out_log[k].data), 64'(32'h100 + k));
                chk($sformatf("t1_ch%0d", k), 64'(out_log[k].ch), 64'd0);
            end
            if (k > 0 && k < acc_cyc.size()) begin
                exp_gap = (k == 4 || k == 8) ? 2 : 1;
                chk($sformatf("t1_gap%0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(exp_gap));
            end
        end

        // Full contention: 0000 1111 2222 3333 0000 ...
        do_reset();
        for (int i = 0; i < NR; i++) src_left[i] = 8;
        drive();
        run_idle("t2", 400);
        chk("t2_beats", 64'(acc_ch.size()), 64'd32);
        for (int k = 0; k < 32; k++) begin
            if (k < acc_ch.size()) begin
                chk($sformatf("t2_grant%0d", k), 64'(acc_ch[k]), 64'((k / 4) % 4));
            end
            if (k < out_log.size()) begin
                chk($sformatf("t2_outch%0d", k), 64'(out_log[k].ch), 64'((k / 4) % 4));
            end
            if (k > 0 && k < acc_cyc.size()) begin
                exp_gap = (k % 4 == 0) ? 2 : 1;
                chk($sformatf("t2_gap%0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(exp_gap));
            end
        end

        // Backpressure on source 2 after its first beat
        do_reset();
        src_left[2] = 6;
        drive();
        wait_acc("t3_first", 1, 10);
        or_val = 1'b0;
        drive();
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("t3_stall_valid", 64'(bus.out_valid), 64'd1);
            chk("t3_stall_data", 64'(bus.out_data), 64'h300);
            chk("t3_stall_ch", 64'(bus.out_channel), 64'd2);
            chk("t3_stall_ready", 64'(bus.in_ready), 64'd0);
            chk("t3_stall_busy", 64'(bus.busy), 64'd1);
        end
        or_val = 1'b1;
        drive();
        run_idle("t3", 100);
        chk("t3_beats", 64'(out_log.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < out_log.size()) begin
                chk($sformatf("t3_data%0d", k), 64'(out_log[k].data), 64'(32'h300 + k));
            end
            if (k > 0 && k < acc_cyc.size()) begin
                chk($sformatf("t3_gap%0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(exp_t3[k-1]));
            end
        end

        // Pointer wrap: after granting 2, source 3 beats source 0
        do_reset();
        src_left[2] = 1;
        drive();
        run_idle("t4a", 50);
        clear_logs();
        src_left[0] = 1;
        src_left[3] = 1;
        drive();
        run_idle("t4b", 50);
        chk("t4_beats", 64'(acc_ch.size()), 64'd2);
        if (acc_ch.size() >= 2) begin
            chk("t4_first", 64'(acc_ch[0]), 64'd3);
            chk("t4_second", 64'(acc_ch[1]), 64'd0);
        end

        // Early release when source 1 runs dry after 2 beats
        do_reset();
        src_left[1] = 2;
        src_left[3] = 4;
        drive();
        run_idle("t5", 100);
        chk("t5_beats", 64'(out_log.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < out_log.size()) begin
                chk($sformatf("t5_outch%0d", k), 64'(out_log[k].ch), 64'(exp_t5[k]));
            end
        end
        if (out_log.size() > 2) chk("t5_data2", 64'(out_log[2].data), 64'h400);

        // Reset during beat 3 of a burst restarts arbitration from index 0
        do_reset();
        src_left[2] = 1;
        drive();
        run_idle("t6a", 50);
        clear_logs();
        src_left[1] = 8;
        src_left[3] = 8;
        drive();
        wait_acc("t6_burst", 3, 20);
        if (acc_ch.size() > 0) chk("t6_pre_ch", 64'(acc_ch[0]), 64'd3);
        areset = 1'b1;
        #2;
        chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_ready", 64'(bus.in_ready), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy), 64'd0);
        chk("t6_rst_data", 64'(bus.out_data), 64'd0);
        sb.delete();
        tick();
        areset = 1'b0;
        clear_logs();
        run_idle("t6", 300);
        chk("t6_beats", 64'(acc_ch.size()), 64'd13);
        if (acc_ch.size() > 4) begin
            chk("t6_first_ch", 64'(acc_ch[0]), 64'd1);
            chk("t6_next_ch", 64'(acc_ch[4]), 64'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
